// File: rtl/dmem_port_arbiter_if.sv
// Request/grant data-memory port bundle shared by the CORE, EXT and memory sides of the arbiter.
// Requesters use master/slave; the arbiter-to-memory hop uses mem_master/mem_slave (no gnt/rvalid).
interface dmem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );

    modport mem_master (
        output req, we, be, addr, wdata,
        input  rdata
    );

    modport mem_slave (
        input  req, we, be, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester data-memory port arbiter: CORE has priority, EXT is forced after MAX_HOLD CORE wins.
// Optional DMEM_ARB_PERF_EN adds saturating per-side wait-cycle counters.
module dmem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    dmem_port_arbiter_if.slave      core_bus,
    dmem_port_arbiter_if.slave      ext_bus,
    dmem_port_arbiter_if.mem_master mem_bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [XLEN-1:0]         core_wait_cnt_o,
    output logic [XLEN-1:0]         ext_wait_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_EXT  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] streak_reg;
    logic [3:0] streak_next;
    logic       last_we_reg;
    logic       ext_forced;
    logic [1:0] req_vec;
    logic [1:0] gnt_vec;
    logic [1:0] rvalid_vec;

    // bit 0 = CORE, bit 1 = EXT throughout
    assign req_vec    = {ext_bus.req, core_bus.req};
    assign ext_forced = (streak_reg == HOLD_LIMIT);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg   <= ST_IDLE;
            streak_reg  <= 4'd0;
            last_we_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            streak_reg  <= streak_next;
            last_we_reg <= mem_bus.we;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        if (gnt_vec[0]) begin
            state_next = ST_CORE;
        end else if (gnt_vec[1]) begin
            state_next = ST_EXT;
        end

        // EXT grant or an idle EXT side both restart the streak
        streak_next = 4'd0;
        if (ext_bus.req && gnt_vec[0]) begin
            streak_next = (streak_reg >= HOLD_LIMIT) ? HOLD_LIMIT : streak_reg + 4'd1;
        end
    end

    always_comb begin
        gnt_vec = 2'b00;
        if (rstn_i) begin
            if (req_vec[0] && !(req_vec[1] && ext_forced)) begin
                gnt_vec = 2'b01;
            end else if (req_vec[1]) begin
                gnt_vec = 2'b10;
            end
        end

        mem_bus.req   = |gnt_vec;
        mem_bus.we    = 1'b0;
        mem_bus.be    = 4'd0;
        mem_bus.addr  = '0;
        mem_bus.wdata = '0;
        if (gnt_vec[0]) begin
            mem_bus.we    = core_bus.we;
            mem_bus.be    = core_bus.be;
            mem_bus.addr  = core_bus.addr;
            mem_bus.wdata = core_bus.wdata;
        end else if (gnt_vec[1]) begin
            mem_bus.we    = ext_bus.we;
            mem_bus.be    = ext_bus.be;
            mem_bus.addr  = ext_bus.addr;
            mem_bus.wdata = ext_bus.wdata;
        end
    end

    assign core_bus.gnt = gnt_vec[0];
    assign ext_bus.gnt  = gnt_vec[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            localparam logic [1:0] OWNER = (gi == 0) ? ST_CORE : ST_EXT;
            assign rvalid_vec[gi] = (state_reg == OWNER) && !last_we_reg;
        end
    endgenerate

    assign core_bus.rvalid = rvalid_vec[0];
    assign core_bus.rdata  = rvalid_vec[0] ? mem_bus.rdata : '0;
    assign ext_bus.rvalid  = rvalid_vec[1];
    assign ext_bus.rdata   = rvalid_vec[1] ? mem_bus.rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [XLEN-1:0] cnt_reg;
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    cnt_reg <= '0;
                end else if (req_vec[gi] && !gnt_vec[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + XLEN'(1);
                end
            end
        end
    endgenerate

    assign core_wait_cnt_o = g_perf[0].cnt_reg;
    assign ext_wait_cnt_o  = g_perf[1].cnt_reg;
`endif

endmodule
